dru_bit_packer: RTL
===================

# dru_bit_packer

Packs the variable-rate bit stream produced by the oversampling data recovery unit (0, 1 or 2 recovered bits per clock) into fixed-width parallel words with a one-cycle valid strobe. It sits directly downstream of `data_recovery_unit`, in the same clock domain. It provides a bitslip control so a downstream word aligner can shift the word boundary one bit at a time.

## Interface
Parameters:
- `WORD_W`, default 8: output word width. Legal range 4..32; at most one word completes per cycle.

Ports:
- `clk` input 1: single clock, shared with `data_recovery_unit`.
- `areset` input 1: asynchronous, active-high reset.
- `bits_in` input 2: recovered bits from the DRU; `bits_in[0]` is earlier in time than `bits_in[1]`.
- `bits_cnt` input 2: number of valid bits in `bits_in`; 0, 1 or 2. Value 3 is illegal. When `bits_cnt`=1, only `bits_in[0]` is valid.
- `bitslip` input 1: single-cycle pulse; discard the next incoming bit.
- `word_out` output WORD_W: packed word; `word_out[0]` is the earliest bit.
- `word_valid` output 1: one-cycle strobe; `word_out` is valid this cycle.
- `fill_level` output clog2(WORD_W) bits: number of bits currently held (0..WORD_W-1).
- `cnt_err` output 1: one-cycle pulse; illegal `bits_cnt`=3 was seen the previous cycle.

## Operation
- State consists of a WORD_W+1-bit accumulator `acc`, a fill counter `fill` (0..WORD_W-1) and a `slip_pending` flag.
- Each cycle, k = `bits_cnt` (treated as 0 when it is 3). If `slip_pending` and k>0, the earliest bit is dropped: k := k-1, and `slip_pending` clears.
- The k surviving bits are written into `acc[fill]`, `acc[fill+1]` in time order, and fill' = fill + k.
- If fill' ≥ WORD_W:
  - `acc[WORD_W-1:0]` is registered to `word_out` and `word_valid` is set.
  - The remaining bit (at most one) moves to `acc[0]`, and fill' -= WORD_W.
- `bitslip` sets `slip_pending`.
  - `bitslip` while `slip_pending` is already set is ignored; slips do not queue.
  - If `bitslip` is asserted in the same cycle as a k>0 beat, the slip applies to that beat's first bit.
- `bits_cnt`=3: no bits are accepted, `fill` and `acc` are unchanged, and `cnt_err` pulses. A pending slip is not consumed.
- `word_out` holds its last value between strobes; it is not cleared.
- No backpressure: a downstream consumer must accept every strobe.

## Timing
- Reset values (asynchronous assert, synchronous to the first `clk` edge after release): `word_out`=0, `word_valid`=0, `fill_level`=0, `cnt_err`=0, `acc`=0, `slip_pending`=0.
- Latency: `word_valid` and `word_out` are registered. They assert on the clock edge that samples the beat completing the word, so they are visible one cycle after that beat is presented.
- `fill_level` is registered and reflects the post-update fill.
- `word_valid` is never high in consecutive cycles: max 2 bits/cycle and WORD_W ≥ 4 give at least 2 cycles between words.
- Boundary cases:
  - fill=WORD_W-1 with k=2: emit word, fill'=1.
  - fill=WORD_W-2 with k=2: emit word, fill'=0.
  - fill=WORD_W-1 with slip and k=1: no word emitted, fill unchanged.
- Reset mid-word: partial bits are discarded and a pending slip is lost. The first word after release is built entirely from post-reset bits.

## Structure
- Shared package `dru_pkg`:
  - `bits_cnt` encoding constants `DRU_CNT_NONE`=0, `DRU_CNT_ONE`=1, `DRU_CNT_TWO`=2, `DRU_CNT_ILLEGAL`=3.
  - A typedef for the 2-bit DRU bit-pair bus.
  - `data_recovery_unit` uses the same package.
- No sub-module: a single module holding the accumulator, fill counter and slip logic.
- A later word-alignment block instantiates this module and drives `bitslip`.

## Test plan
- 1 bit/cycle sequence 1,0,1,1,0,0,1,0 after reset, WORD_W=8 → one `word_valid` pulse, `word_out`=8'h4D, `fill_level`=0 afterwards.
- Four beats of 2 bits/cycle with `bits_in`=2'b01 → `word_out`=8'h55 after the 4th beat. Then 100 cycles with `bits_cnt`=0 → no strobe, `word_out` holds 8'h55.
- Mixed: seven 1-bit beats of 1, then one 2-bit beat {`bits_in[1]`=0, `bits_in[0]`=1} → `word_out`=8'hFF, `fill_level`=1. The next seven 1-bit beats of 1 give `word_out`=8'hFE.
- `bitslip` asserted with the first of nine 1-bit beats 0,1,1,1,1,1,1,1,1 → leading 0 dropped, `word_out`=8'hFF. A second `bitslip` while pending is ignored: exactly one bit is dropped.
- `bits_cnt`=3 for one cycle at `fill_level`=3 → `cnt_err` pulses one cycle later, `fill_level` stays 3, no strobe.
- `areset` asserted at `fill_level`=5 with a slip pending → all outputs 0 immediately. After release, 8 beats of 1 give `word_out`=8'hFF with no bit dropped.

Source files
------------

// File: rtl/dru_pkg.sv
// Shared definitions for the DRU datapath: bit-count encoding and bit-pair bus.
package dru_pkg;

    // bits_cnt encodings driven by data_recovery_unit
    localparam logic [1:0] DRU_CNT_NONE    = 2'd0;
    localparam logic [1:0] DRU_CNT_ONE     = 2'd1;
    localparam logic [1:0] DRU_CNT_TWO     = 2'd2;
    localparam logic [1:0] DRU_CNT_ILLEGAL = 2'd3;

    // Recovered bit pair; bit 0 is earlier in time than bit 1
    typedef logic [1:0] dru_bits_t;

    // Number of bits actually accepted for a given count (illegal counts accept none)
    function automatic logic [1:0] dru_cnt_bits(input logic [1:0] cnt);
        return (cnt == DRU_CNT_ILLEGAL) ? DRU_CNT_NONE : cnt;
    endfunction

endpackage

// File: rtl/dru_bit_packer.sv
// Packs the 0/1/2-bit-per-cycle DRU stream into WORD_W-bit words with a
// one-cycle valid strobe, plus a bitslip that drops the next incoming bit.
module dru_bit_packer
    import dru_pkg::*;
#(
    parameter int WORD_W = 8
) (
    input  logic                      clk,
    input  logic                      areset,
    input  logic [1:0]                bits_in,
    input  logic [1:0]                bits_cnt,
    input  logic                      bitslip,
    output logic [WORD_W-1:0]         word_out,
    output logic                      word_valid,
    output logic [$clog2(WORD_W)-1:0] fill_level,
    output logic                      cnt_err
);

    localparam int FW = $clog2(WORD_W);       // fill counter width
    localparam int SW = FW + 1;               // fill + k can reach WORD_W+1
    localparam int AW = $clog2(WORD_W + 1);   // accumulator index width
    localparam logic [SW-1:0] WORD_W_C = SW'(WORD_W);

    logic [WORD_W:0]   r_acc;
    logic [FW-1:0]     r_fill;
    logic              r_slip_pending;
    logic [WORD_W-1:0] r_word;
    logic              r_valid;
    logic              r_cnt_err;

    dru_bits_t         w_bits;
    logic              w_illegal;
    logic [1:0]        w_k;
    logic              w_slip_req;
    logic              w_drop;
    logic [1:0]        w_k_eff;
    logic              w_b0;
    logic              w_b1;
    logic [AW-1:0]     w_i0;
    logic [AW-1:0]     w_i1;
    logic [WORD_W:0]   w_acc;
    logic [SW-1:0]     w_sum;
    logic              w_emit;
    logic [FW-1:0]     w_fill_nxt;
    logic              w_slip_nxt;
    logic [WORD_W:0]   w_acc_nxt;

    assign w_bits = bits_in;

    // Beat decode: apply slip, write surviving bits at the fill point, detect word completion
    always_comb begin
        w_illegal  = (bits_cnt == DRU_CNT_ILLEGAL);
        w_k        = dru_cnt_bits(bits_cnt);
        w_slip_req = r_slip_pending | bitslip;
        w_drop     = w_slip_req && (w_k != DRU_CNT_NONE);
        w_k_eff    = w_drop ? (w_k - 2'd1) : w_k;
        // After a drop only the later bit (if any) survives
        w_b0       = w_drop ? w_bits[1] : w_bits[0];
        w_b1       = w_bits[1];
        w_i0       = AW'(r_fill);
        w_i1       = AW'(r_fill) + AW'(1);

        w_acc = r_acc;
        if (w_k_eff != DRU_CNT_NONE)
            w_acc[w_i0] = w_b0;
        if (w_k_eff == DRU_CNT_TWO)
            w_acc[w_i1] = w_b1;

        w_sum      = SW'(r_fill) + SW'(w_k_eff);
        w_emit     = (w_sum >= WORD_W_C);
        w_fill_nxt = w_emit ? FW'(w_sum - WORD_W_C) : FW'(w_sum);
        // Overflow bit (only present when fill was WORD_W-1 with two bits) becomes bit 0
        w_acc_nxt  = w_emit ? {{WORD_W{1'b0}}, w_acc[WORD_W]} : w_acc;

        // An illegal beat leaves a pending slip in place; otherwise a drop consumes it
        if (w_illegal)
            w_slip_nxt = w_slip_req;
        else
            w_slip_nxt = w_slip_req && !w_drop;
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_acc          <= '0;
            r_fill         <= '0;
            r_slip_pending <= 1'b0;
            r_word         <= '0;
            r_valid        <= 1'b0;
            r_cnt_err      <= 1'b0;
        end else begin
            r_acc          <= w_acc_nxt;
            r_fill         <= w_fill_nxt;
            r_slip_pending <= w_slip_nxt;
            r_valid        <= w_emit;
            r_cnt_err      <= w_illegal;
            if (w_emit)
                r_word <= w_acc[WORD_W-1:0];
        end
    end

    assign word_out   = r_word;
    assign word_valid = r_valid;
    assign fill_level = r_fill;
    assign cnt_err    = r_cnt_err;

endmodule
